// File: rtl/return_addr_stack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : return_addr_stack_pkg
//  Description : Shared branch type codes, checkpoint width derivation and
//                the RAS_CKPT_REPAIR_EN build option for the return stack.
//  Revision    : 1.0 - initial release
// ============================================================================
package return_addr_stack_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_CALL = 2'd1,
        BR_RET  = 2'd2
    } br_type_e;

    // Return address is the call PC plus the call and its delay slot.
    localparam int unsigned c_call_offset = 8;

    // Checkpoint layout, MSB first: {ptr, count, top value}.
    function automatic int ckpt_width(input int depth, input int addr_w);
        return $clog2(depth) + ($clog2(depth) + 1) + addr_w;
    endfunction

    // RAS_CKPT_REPAIR_EN is left undefined by default: pointer-only restore.
`ifdef RAS_CKPT_REPAIR_EN
    localparam bit c_ckpt_repair_en = 1'b1;
`else
    localparam bit c_ckpt_repair_en = 1'b0;
`endif

endpackage : return_addr_stack_pkg
`default_nettype wire

// File: rtl/ras_storage.sv
`default_nettype none
// ============================================================================
//  Module      : ras_storage
//  Description : DEPTH x ADDR_W return-address array, one synchronous write
//                port and one combinational read port; data is not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ras_storage #(
    parameter  int DEPTH  = 16,
    parameter  int ADDR_W = 32,
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [PW-1:0]     i_waddr,
    input  logic [ADDR_W-1:0] i_wdata,
    input  logic [PW-1:0]     i_raddr,
    output logic [ADDR_W-1:0] o_rdata
);

    logic [ADDR_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : ras_storage
`default_nettype wire

// File: rtl/return_addr_stack.sv
`default_nettype none
// ============================================================================
//  Module      : return_addr_stack
//  Description : Multi-lane return address stack with checkpoint/flush
//                repair. Build option: RAS_CKPT_REPAIR_EN (top-value repair).
//  Revision    : 1.0 - initial release
// ============================================================================
module return_addr_stack
    import return_addr_stack_pkg::*;
#(
    parameter  int DEPTH  = 16,
    parameter  int ADDR_W = 32,
    parameter  int LANES  = 2,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1,
    localparam int CKPT_W = ckpt_width(DEPTH, ADDR_W)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    stall,
    input  logic [LANES-1:0]        lane_vld,
    input  logic [LANES-1:0]        lane_call,
    input  logic [LANES-1:0]        lane_ret,
    input  logic [LANES*ADDR_W-1:0] lane_pc,
    output logic                    ret_valid,
    output logic [ADDR_W-1:0]       ret_target,
    output logic [CKPT_W-1:0]       ckpt_o,
    input  logic                    flush_i,
    input  logic [CKPT_W-1:0]       flush_ckpt_i,
    output logic [CW-1:0]           count_o
);

    logic [PW-1:0]     r_ptr;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     w_ptr_nxt;
    logic [CW-1:0]     w_count_nxt;
    br_type_e          w_type;
    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_top;
    logic [ADDR_W-1:0] w_call_addr;
    logic              w_pop;
    logic              w_we;
    logic [PW-1:0]     w_waddr;
    logic [ADDR_W-1:0] w_wdata;
    logic [PW-1:0]     w_fl_ptr;
    logic [CW-1:0]     w_fl_count;
    logic [ADDR_W-1:0] w_fl_top;

    // Scan from the top lane down so the lowest qualifying lane wins.
    always_comb begin
        w_type = BR_NONE;
        w_pc   = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_vld[i] && (lane_call[i] || lane_ret[i])) begin
                w_type = lane_call[i] ? BR_CALL : BR_RET;
                w_pc   = lane_pc[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_call_addr = w_pc + ADDR_W'(c_call_offset);
    assign w_pop       = (w_type == BR_RET) && (r_count != '0);
    assign ret_valid   = resetn && w_pop;
    assign ret_target  = ret_valid ? w_top : '0;
    assign ckpt_o      = {r_ptr, r_count, w_top};
    assign count_o     = r_count;

    assign w_fl_ptr    = flush_ckpt_i[CKPT_W-1 -: PW];
    assign w_fl_count  = flush_ckpt_i[ADDR_W +: CW];
    assign w_fl_top    = flush_ckpt_i[ADDR_W-1:0];

    always_comb begin
        w_ptr_nxt   = r_ptr;
        w_count_nxt = r_count;
        w_we        = 1'b0;
        w_waddr     = r_ptr + PW'(1);
        w_wdata     = w_call_addr;
        if (flush_i) begin
            w_ptr_nxt   = w_fl_ptr;
            w_count_nxt = w_fl_count;
            w_we        = c_ckpt_repair_en;
            w_waddr     = w_fl_ptr;
            w_wdata     = w_fl_top;
        end else if (!stall) begin
            if (w_type == BR_CALL) begin
                w_ptr_nxt   = r_ptr + PW'(1);
                w_count_nxt = (r_count == CW'(DEPTH)) ? r_count : r_count + CW'(1);
                w_we        = 1'b1;
            end else if (w_pop) begin
                w_ptr_nxt   = r_ptr - PW'(1);
                w_count_nxt = r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ptr   <= PW'(DEPTH - 1);
            r_count <= '0;
        end else begin
            r_ptr   <= w_ptr_nxt;
            r_count <= w_count_nxt;
        end
    end

    ras_storage #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_storage (
        .clk     (clk),
        .i_we    (w_we && resetn),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_ptr),
        .o_rdata (w_top)
    );

endmodule : return_addr_stack
`default_nettype wire

// File: tb/tb_return_addr_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_return_addr_stack
//  Description : Directed self-checking bench for return_addr_stack.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_return_addr_stack;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 32;
    localparam int LANES  = 2;
    localparam int CKPT_W = 41;

`ifdef RAS_CKPT_REPAIR_EN
    localparam logic [31:0] c_flush_ret_exp = 32'h3008;
`else
    localparam logic [31:0] c_flush_ret_exp = 32'h4008;
`endif

    logic                    clk = 1'b0;
    logic                    resetn;
    logic                    stall;
    logic [LANES-1:0]        lane_vld;
    logic [LANES-1:0]        lane_call;
    logic [LANES-1:0]        lane_ret;
    logic [LANES*ADDR_W-1:0] lane_pc;
    logic                    ret_valid;
    logic [ADDR_W-1:0]       ret_target;
    logic [CKPT_W-1:0]       ckpt_o;
    logic                    flush_i;
    logic [CKPT_W-1:0]       flush_ckpt_i;
    logic [4:0]              count_o;

    int checks   = 0;
    int failures = 0;

    logic [CKPT_W-1:0] r_saved;

    return_addr_stack #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .LANES  (LANES)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .stall        (stall),
        .lane_vld     (lane_vld),
        .lane_call    (lane_call),
        .lane_ret     (lane_ret),
        .lane_pc      (lane_pc),
        .ret_valid    (ret_valid),
        .ret_target   (ret_target),
        .ckpt_o       (ckpt_o),
        .flush_i      (flush_i),
        .flush_ckpt_i (flush_ckpt_i),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        lane_vld  = '0;
        lane_call = '0;
        lane_ret  = '0;
        lane_pc   = '0;
    endtask

    task automatic drive(input int lane, input bit c, input bit r, input logic [31:0] pc);
        lane_vld[lane]          = 1'b1;
        lane_call[lane]         = c;
        lane_ret[lane]          = r;
        lane_pc[lane*32 +: 32]  = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        resetn  = 1'b0;
        stall   = 1'b0;
        flush_i = 1'b0;
        flush_ckpt_i = '0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic call(input logic [31:0] pc);
        idle();
        drive(0, 1'b1, 1'b0, pc);
        step();
    endtask

    task automatic ret_expect(input string tag, input logic [31:0] exp);
        idle();
        drive(0, 1'b0, 1'b1, 32'h0);
        #1;
        check({tag, "_valid"}, 64'(ret_valid), 64'd1);
        check({tag, "_target"}, 64'(ret_target), 64'(exp));
        step();
    endtask

    initial begin
        logic [CKPT_W-1:0] ck;
        do_reset();

        // Reset state
        ck = ckpt_o;
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_valid", 64'(ret_valid), 64'd0);
        check("rst_target", 64'(ret_target), 64'd0);
        check("rst_ptr", 64'(ck[40:37]), 64'd15);

        // Single call/return
        call(32'h1000);
        check("call1_count", 64'(count_o), 64'd1);
        ret_expect("ret1", 32'h1008);
        check("ret1_count", 64'(count_o), 64'd0);

        // Return on empty stack
        drive(0, 1'b0, 1'b1, 32'h0);
        #1;
        check("empty_valid", 64'(ret_valid), 64'd0);
        check("empty_target", 64'(ret_target), 64'd0);
        step();
        ck = ckpt_o;
        check("empty_count", 64'(count_o), 64'd0);
        check("empty_ptr", 64'(ck[40:37]), 64'd15);

        // Lane0 return wins over lane1 call
        call(32'h2000);
        drive(0, 1'b0, 1'b1, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h7000);
        #1;
        check("prio_target", 64'(ret_target), 64'h2008);
        step();
        check("prio_count", 64'(count_o), 64'd0);

        // Lane0 not valid, lane1 active; lane0 valid but typeless is skipped
        lane_call[0] = 1'b1;
        drive(1, 1'b1, 1'b0, 32'h6000);
        step();
        check("lane1_call_count", 64'(count_o), 64'd1);
        lane_vld[0] = 1'b1;
        drive(1, 1'b0, 1'b1, 32'h0);
        #1;
        check("lane1_ret_target", 64'(ret_target), 64'h6008);
        step();
        check("lane1_ret_count", 64'(count_o), 64'd0);

        // Call and return on the same lane acts as a call
        drive(0, 1'b1, 1'b1, 32'h8000);
        #1;
        check("both_valid", 64'(ret_valid), 64'd0);
        step();
        check("both_count", 64'(count_o), 64'd1);
        ret_expect("both_ret", 32'h8008);

        // Overflow: 17 calls, 16 returns, then empty
        for (int k = 1; k <= 17; k++) call(32'(k * 32'h100));
        check("ovf_count", 64'(count_o), 64'd16);
        for (int i = 0; i < 16; i++) ret_expect("ovf_ret", 32'((17 - i) * 32'h100 + 8));
        check("ovf_empty_count", 64'(count_o), 64'd0);
        drive(0, 1'b0, 1'b1, 32'h0);
        #1;
        check("ovf_17th_valid", 64'(ret_valid), 64'd0);
        step();

        // Checkpoint and flush repair after a wrong-path pop and push
        do_reset();
        call(32'h2000);
        call(32'h3000);
        r_saved = ckpt_o;
        check("ckpt_count", 64'(r_saved[36:32]), 64'd2);
        check("ckpt_top", 64'(r_saved[31:0]), 64'h3008);
        ret_expect("wp_ret", 32'h3008);
        call(32'h4000);
        flush_i      = 1'b1;
        flush_ckpt_i = r_saved;
        drive(0, 1'b1, 1'b0, 32'h9000);
        step();
        flush_i = 1'b0;
        check("flush_count", 64'(count_o), 64'd2);
        ret_expect("flush_ret", c_flush_ret_exp);
        ret_expect("flush_ret2", 32'h2008);

        // Stall holds state; flush still acts under stall
        do_reset();
        r_saved = ckpt_o;
        call(32'h1000);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, 1'b0, 32'h5000);
            step();
            check("stall_count", 64'(count_o), 64'd1);
        end
        drive(0, 1'b0, 1'b1, 32'h0);
        #1;
        check("stall_ret_target", 64'(ret_target), 64'h1008);
        step();
        check("stall_ret_count", 64'(count_o), 64'd1);
        flush_i      = 1'b1;
        flush_ckpt_i = r_saved;
        drive(0, 1'b1, 1'b0, 32'h5000);
        step();
        flush_i = 1'b0;
        stall   = 1'b0;
        ck = ckpt_o;
        check("stall_flush_count", 64'(count_o), 64'd0);
        check("stall_flush_ptr", 64'(ck[40:37]), 64'd15);

        // Reset overrides flush and stall
        call(32'h1000);
        r_saved = ckpt_o;
        call(32'h2000);
        resetn       = 1'b0;
        flush_i      = 1'b1;
        stall        = 1'b1;
        flush_ckpt_i = r_saved;
        step();
        resetn  = 1'b1;
        flush_i = 1'b0;
        stall   = 1'b0;
        ck = ckpt_o;
        check("rst_flush_count", 64'(count_o), 64'd0);
        check("rst_flush_ptr", 64'(ck[40:37]), 64'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_return_addr_stack
`default_nettype wire
